// File: rtl/scr1_dmem_bist.sv
// Dmem-side self-test initiator: writes seed+i over a word region, reads it back and reports pass/fail.
// One transaction in flight; REQ states hold all fields until req_ack, RESP states wait out NOTRDY.
module scr1_dmem_bist #(
  parameter int SCR1_BIST_CNT_W = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       start_i,
  input  logic [31:0]                base_addr_i,
  input  logic [SCR1_BIST_CNT_W-1:0] word_cnt_i,
  input  logic [31:0]                seed_i,
  output logic                       busy_o,
  output logic                       done_o,
  output logic                       pass_o,
  output logic                       bus_err_o,
  output logic [SCR1_BIST_CNT_W-1:0] err_cnt_o,
  output logic [31:0]                fail_addr_o,
  output logic [31:0]                fail_exp_o,
  output logic [31:0]                fail_act_o,
  output logic                       dmem_req_o,
  output logic                       dmem_cmd_o,
  output logic [1:0]                 dmem_width_o,
  output logic [31:0]                dmem_addr_o,
  output logic [31:0]                dmem_wdata_o,
  input  logic                       dmem_req_ack_i,
  input  logic [31:0]                dmem_rdata_i,
  input  logic [1:0]                 dmem_resp_i
);

  localparam int CNT_W = SCR1_BIST_CNT_W;
  localparam logic [1:0] RESP_OK = 2'b01;
  localparam logic [1:0] RESP_ER = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_REQ,
    ST_WR_RESP,
    ST_RD_REQ,
    ST_RD_RESP,
    ST_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [31:0]      base_q, base_d;
  logic [31:0]      seed_q, seed_d;
  logic [CNT_W-1:0] last_q, last_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [31:0]      fail_addr_q, fail_addr_d;
  logic [31:0]      fail_exp_q, fail_exp_d;
  logic [31:0]      fail_act_q, fail_act_d;
  logic             pass_q, pass_d;
  logic             bus_err_q, bus_err_d;

  logic [31:0] idx_ext;
  logic [31:0] cur_addr;
  logic [31:0] cur_data;
  logic        is_last;
  logic        resp_ok;
  logic        resp_er;
  logic        mismatch;

  assign idx_ext  = 32'(idx_q);
  assign cur_addr = base_q + (idx_ext << 2);
  assign cur_data = seed_q + idx_ext;
  assign is_last  = (idx_q == last_q);
  assign resp_ok  = (dmem_resp_i == RESP_OK);
  assign resp_er  = (dmem_resp_i == RESP_ER);
  assign mismatch = (state_q == ST_RD_RESP) && resp_ok && (dmem_rdata_i != cur_data);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = (word_cnt_i == '0) ? ST_DONE : ST_WR_REQ;
        end
      end
      ST_WR_REQ: begin
        if (dmem_req_ack_i) state_d = ST_WR_RESP;
      end
      ST_WR_RESP: begin
        if (resp_ok)      state_d = is_last ? ST_RD_REQ : ST_WR_REQ;
        else if (resp_er) state_d = ST_DONE;
      end
      ST_RD_REQ: begin
        if (dmem_req_ack_i) state_d = ST_RD_RESP;
      end
      ST_RD_RESP: begin
        if (resp_ok)      state_d = is_last ? ST_DONE : ST_RD_REQ;
        else if (resp_er) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy_o     = 1'b0;
    done_o     = 1'b0;
    dmem_req_o = 1'b0;
    dmem_cmd_o = 1'b0;
    case (state_q)
      ST_WR_REQ: begin
        busy_o     = 1'b1;
        dmem_req_o = 1'b1;
        dmem_cmd_o = 1'b1;
      end
      ST_WR_RESP: busy_o = 1'b1;
      ST_RD_REQ: begin
        busy_o     = 1'b1;
        dmem_req_o = 1'b1;
      end
      ST_RD_RESP: busy_o = 1'b1;
      ST_DONE:    done_o = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    base_d      = base_q;
    seed_d      = seed_q;
    last_d      = last_q;
    idx_d       = idx_q;
    err_cnt_d   = err_cnt_q;
    fail_addr_d = fail_addr_q;
    fail_exp_d  = fail_exp_q;
    fail_act_d  = fail_act_q;
    pass_d      = pass_q;
    bus_err_d   = bus_err_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          base_d      = base_addr_i & 32'hFFFF_FFFC;
          seed_d      = seed_i;
          last_d      = word_cnt_i - CNT_W'(1);
          idx_d       = '0;
          err_cnt_d   = '0;
          fail_addr_d = '0;
          fail_exp_d  = '0;
          fail_act_d  = '0;
          bus_err_d   = 1'b0;
          // An empty region has nothing to fail, so it completes as a pass.
          pass_d      = (word_cnt_i == '0);
        end
      end
      ST_WR_RESP, ST_RD_RESP: begin
        if (resp_ok)      idx_d     = is_last ? '0 : idx_q + CNT_W'(1);
        else if (resp_er) bus_err_d = 1'b1;
      end
      default: ;
    endcase
    if (mismatch) begin
      if (err_cnt_q != '1) err_cnt_d = err_cnt_q + CNT_W'(1);
      if (err_cnt_q == '0) begin
        fail_addr_d = cur_addr;
        fail_exp_d  = cur_data;
        fail_act_d  = dmem_rdata_i;
      end
    end
    // Resolve pass on the final read so it is already valid during the done pulse.
    if ((state_q == ST_RD_RESP) && resp_ok && is_last) begin
      pass_d = (err_cnt_q == '0) && !mismatch;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      base_q      <= '0;
      seed_q      <= '0;
      last_q      <= '0;
      idx_q       <= '0;
      err_cnt_q   <= '0;
      fail_addr_q <= '0;
      fail_exp_q  <= '0;
      fail_act_q  <= '0;
      pass_q      <= 1'b0;
      bus_err_q   <= 1'b0;
    end else begin
      base_q      <= base_d;
      seed_q      <= seed_d;
      last_q      <= last_d;
      idx_q       <= idx_d;
      err_cnt_q   <= err_cnt_d;
      fail_addr_q <= fail_addr_d;
      fail_exp_q  <= fail_exp_d;
      fail_act_q  <= fail_act_d;
      pass_q      <= pass_d;
      bus_err_q   <= bus_err_d;
    end
  end

  assign pass_o       = pass_q;
  assign bus_err_o    = bus_err_q;
  assign err_cnt_o    = err_cnt_q;
  assign fail_addr_o  = fail_addr_q;
  assign fail_exp_o   = fail_exp_q;
  assign fail_act_o   = fail_act_q;
  assign dmem_width_o = 2'b10;
  assign dmem_addr_o  = cur_addr;
  assign dmem_wdata_o = cur_data;

endmodule

// File: tb/tb_scr1_dmem_bist.sv
// Bench for scr1_dmem_bist: memory responder with stalls/errors/corruption, scoreboard of requests and results.
module tb_scr1_dmem_bist;

  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [31:0]      base_addr;
  logic [CNT_W-1:0] word_cnt;
  logic [31:0]      seed;
  logic             busy, done, pass, bus_err;
  logic [CNT_W-1:0] err_cnt;
  logic [31:0]      fail_addr, fail_exp, fail_act;
  logic             dmem_req, dmem_cmd;
  logic [1:0]       dmem_width;
  logic [31:0]      dmem_addr, dmem_wdata;
  logic             req_ack;
  logic [31:0]      rdata;
  logic [1:0]       resp;

  always #5 clk = ~clk;

  scr1_dmem_bist #(.SCR1_BIST_CNT_W(CNT_W)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .base_addr_i(base_addr),
    .word_cnt_i(word_cnt), .seed_i(seed), .busy_o(busy), .done_o(done),
    .pass_o(pass), .bus_err_o(bus_err), .err_cnt_o(err_cnt),
    .fail_addr_o(fail_addr), .fail_exp_o(fail_exp), .fail_act_o(fail_act),
    .dmem_req_o(dmem_req), .dmem_cmd_o(dmem_cmd), .dmem_width_o(dmem_width),
    .dmem_addr_o(dmem_addr), .dmem_wdata_o(dmem_wdata), .dmem_req_ack_i(req_ack),
    .dmem_rdata_i(rdata), .dmem_resp_i(resp)
  );

  typedef struct {
    logic        cmd;
    logic [31:0] addr;
    logic [31:0] data;
  } tx_t;

  typedef struct {
    logic        pass;
    logic        bus_err;
    logic [15:0] err_cnt;
    logic [31:0] fa, fe, fact;
    int          start_cyc;
    int          ntx;
  } res_t;

  tx_t  exp_tx[$];
  res_t exp_res[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;

  // Responder configuration and state
  int          err_wr = -1, wr_num = 0, rd_num = 0;
  logic [31:0] corrupt_mask = 0;
  bit          corrupt_fixed = 0;
  logic [31:0] corrupt_val = 0;
  bit          stall_en = 0;
  int          stall_cnt = 0;
  bit          hs_flag = 0;
  tx_t         hs_tx;
  bit          pend = 0;
  tx_t         pend_tx;
  int          left = 0;
  logic [31:0] mem [logic [31:0]];
  int          done_cnt = 0, rd_hs_cnt = 0;

  logic        prev_req = 0, prev_ack = 0, prev_cmd = 0;
  logic [31:0] prev_addr = 0, prev_wdata = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_pass"}, pass, 0);
    check({tag, "_bus_err"}, bus_err, 0);
    check({tag, "_err_cnt"}, err_cnt, 0);
    check({tag, "_fail_addr"}, fail_addr, 0);
    check({tag, "_fail_exp"}, fail_exp, 0);
    check({tag, "_fail_act"}, fail_act, 0);
    check({tag, "_req"}, dmem_req, 0);
    check({tag, "_cmd"}, dmem_cmd, 0);
    check({tag, "_addr"}, dmem_addr, 0);
    check({tag, "_wdata"}, dmem_wdata, 0);
    check({tag, "_width"}, dmem_width, 2'b10);
  endtask

  // Memory responder: accepts requests (optionally with ack-low cycles), answers after optional NOTRDY cycles.
  always @(posedge clk) begin
    #1;
    req_ack = 1'b0;
    resp    = 2'b00;
    rdata   = 32'h0;
    if (rst) begin
      pend    = 1'b0;
      hs_flag = 1'b0;
    end else begin
      if (hs_flag) begin
        pend    = 1'b1;
        pend_tx = hs_tx;
        left    = stall_en ? int'($urandom_range(0, 2)) : 0;
        hs_flag = 1'b0;
      end
      if (pend) begin
        if (left > 0) begin
          left--;
          stall_cnt++;
        end else begin
          pend = 1'b0;
          if (pend_tx.cmd) begin
            if (wr_num == err_wr) resp = 2'b10;
            else begin
              mem[pend_tx.addr] = pend_tx.data;
              resp = 2'b01;
            end
            wr_num++;
          end else begin
            rdata = mem.exists(pend_tx.addr) ? mem[pend_tx.addr] : 32'h0;
            if (rd_num < 32 && corrupt_mask[rd_num]) rdata = corrupt_fixed ? corrupt_val : ~rdata;
            rd_num++;
            resp = 2'b01;
          end
        end
      end else if (dmem_req) begin
        req_ack = stall_en ? ($urandom_range(0, 2) != 0) : 1'b1;
        if (!req_ack) stall_cnt++;
      end
    end
  end

  // Monitor: compares every accepted request and every done pulse against the scoreboard.
  always @(negedge clk) begin
    if (rst) begin
      prev_req = 1'b0;
    end else begin
      if (pend || resp != 2'b00) check("req_in_resp", dmem_req, 0);
      if (prev_req && !prev_ack) begin
        check("hold_req", dmem_req, 1);
        check("hold_cmd", dmem_cmd, prev_cmd);
        check("hold_addr", dmem_addr, prev_addr);
        check("hold_wdata", dmem_wdata, prev_wdata);
      end
      if (dmem_req && req_ack) begin
        if (exp_tx.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_req: got cmd=%0d addr=0x%08h required none", dmem_cmd, dmem_addr);
        end else begin
          tx_t t;
          t = exp_tx.pop_front();
          check("tx_cmd", dmem_cmd, t.cmd);
          check("tx_addr", dmem_addr, t.addr);
          if (t.cmd) check("tx_wdata", dmem_wdata, t.data);
          check("tx_width", dmem_width, 2'b10);
          check("tx_busy", busy, 1);
        end
        hs_flag = 1'b1;
        hs_tx.cmd  = dmem_cmd;
        hs_tx.addr = dmem_addr;
        hs_tx.data = dmem_wdata;
        if (!dmem_cmd) rd_hs_cnt++;
      end
      if (done) begin
        done_cnt++;
        if (exp_res.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_done: got done at cycle %0d required none", cyc);
        end else begin
          res_t r;
          r = exp_res.pop_front();
          check("res_pass", pass, r.pass);
          check("res_bus_err", bus_err, r.bus_err);
          check("res_err_cnt", err_cnt, r.err_cnt);
          check("res_fail_addr", fail_addr, r.fa);
          check("res_fail_exp", fail_exp, r.fe);
          check("res_fail_act", fail_act, r.fact);
          check("res_busy_at_done", busy, 0);
          check("res_done_cycle", cyc, r.start_cyc + 1 + 2 * r.ntx + stall_cnt);
          check("res_tx_left", exp_tx.size(), 0);
        end
      end
      prev_req   = dmem_req;
      prev_ack   = req_ack;
      prev_cmd   = dmem_cmd;
      prev_addr  = dmem_addr;
      prev_wdata = dmem_wdata;
    end
  end

  // Reference model: the full transaction list and final result follow directly from the test rules.
  task automatic start_test(input logic [31:0] b, input int n, input logic [31:0] s, input int ewr,
                            input logic [31:0] cmask, input bit cfix, input logic [31:0] cval,
                            input bit stl);
    logic [31:0] bb, act;
    res_t r;
    tx_t t;
    bit   berr;
    @(posedge clk);
    #1;
    bb   = b & 32'hFFFF_FFFC;
    berr = 0;
    r.ntx = 0;
    r.err_cnt = 0;
    r.fa = 0;
    r.fe = 0;
    r.fact = 0;
    for (int i = 0; i < n; i++) begin
      t.cmd = 1'b1;
      t.addr = bb + 32'(4 * i);
      t.data = s + 32'(i);
      exp_tx.push_back(t);
      r.ntx++;
      if (i == ewr) begin
        berr = 1;
        break;
      end
    end
    if (!berr) begin
      for (int i = 0; i < n; i++) begin
        t.cmd = 1'b0;
        t.addr = bb + 32'(4 * i);
        t.data = s + 32'(i);
        exp_tx.push_back(t);
        r.ntx++;
        if (i < 32 && cmask[i]) begin
          act = cfix ? cval : ~(s + 32'(i));
          if (act != s + 32'(i)) begin
            if (r.err_cnt == 0) begin
              r.fa = t.addr;
              r.fe = t.data;
              r.fact = act;
            end
            r.err_cnt++;
          end
        end
      end
    end
    r.bus_err   = berr;
    r.pass      = !berr && (r.err_cnt == 0);
    r.start_cyc = cyc;
    exp_res.push_back(r);
    err_wr = ewr;
    wr_num = 0;
    rd_num = 0;
    corrupt_mask = cmask;
    corrupt_fixed = cfix;
    corrupt_val = cval;
    stall_en = stl;
    stall_cnt = 0;
    base_addr = b;
    word_cnt = CNT_W'(n);
    seed = s;
    start = 1'b1;
  endtask

  task automatic wait_done(input bit noise, input bit sid);
    int target;
    int k;
    target = done_cnt + 1;
    for (k = 0; k < 3000; k++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      if (noise) begin
        base_addr = $urandom;
        seed = $urandom;
        word_cnt = CNT_W'($urandom);
      end
      if (done_cnt == target) break;
      if (sid && done) start = 1'b1;
      else if (noise && busy && $urandom_range(0, 3) == 0) start = 1'b1;
    end
    if (k == 3000) begin
      n_checks++;
      n_fail++;
      $display("FAIL timeout: got no done within 3000 cycles required done");
      exp_tx.delete();
      exp_res.delete();
    end else if (sid) begin
      @(negedge clk);
      check("start_in_done_busy", busy, 0);
      check("start_in_done_req", dmem_req, 0);
    end
  endtask

  task automatic run_test(input logic [31:0] b, input int n, input logic [31:0] s, input int ewr,
                          input logic [31:0] cmask, input bit cfix, input logic [31:0] cval,
                          input bit stl, input bit noise, input bit sid);
    start_test(b, n, s, ewr, cmask, cfix, cval, stl);
    wait_done(noise, sid);
  endtask

  initial begin
    int          n, e, d0, k;
    logic [31:0] b, s, m;
    rst = 1'b1;
    start = 1'b0;
    base_addr = 0;
    word_cnt = 0;
    seed = 0;
    req_ack = 0;
    rdata = 0;
    resp = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;

    run_test(32'h100, 4, 32'hA5A5_0000, -1, 0, 0, 0, 0, 0, 0);
    run_test(32'h100, 4, 32'hA5A5_0000, -1, 32'h4, 1, 32'hDEAD_BEEF, 0, 0, 0);
    run_test(32'h100, 8, 32'h1111_0000, 1, 0, 0, 0, 0, 0, 0);
    run_test(32'h40, 0, 32'h5555_5555, -1, 0, 0, 0, 0, 0, 0);
    run_test(32'hFFFF_FFF8, 3, 32'h0BAD_F00D, -1, 0, 0, 0, 0, 0, 0);
    run_test(32'h303, 3, 32'hFFFF_FFFF, -1, 0, 0, 0, 0, 0, 0);
    run_test(32'h500, 2, 32'h7777_0000, -1, 32'h3, 0, 0, 0, 0, 1);
    run_test(32'h100, 4, 32'hA5A5_0000, -1, 0, 0, 0, 1, 1, 0);

    for (int t = 0; t < 8; t++) begin
      n = $urandom_range(1, 12);
      b = $urandom;
      s = $urandom;
      m = (t % 2 == 1) ? ($urandom & $urandom & $urandom) : 32'h0;
      e = (t == 5) ? int'($urandom_range(0, n - 1)) : -1;
      run_test(b, n, s, e, m, 0, 0, 1, 1, 0);
    end

    // Abort a test while a read response is pending, then run a clean one.
    start_test(32'h200, 4, 32'h1234_0000, -1, 0, 0, 0, 0);
    for (k = 0; k < 200; k++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      if (rd_hs_cnt > 0 && exp_tx.size() <= 2) break;
    end
    check("reach_rd_resp", (k < 200) ? 1 : 0, 1);
    rst = 1'b1;
    pend = 1'b0;
    exp_tx.delete();
    exp_res.delete();
    d0 = done_cnt;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_idle_outputs("rst_mid");
    repeat (5) @(negedge clk);
    check("no_done_after_rst", done_cnt, d0);
    run_test(32'h200, 4, 32'h1234_0000, -1, 0, 0, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
